// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, legality check and response flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSll  = 4'b0001,
    OpSlt  = 4'b0010,
    OpSltu = 4'b0011,
    OpXor  = 4'b0100,
    OpSrl  = 4'b0101,
    OpOr   = 4'b0110,
    OpAnd  = 4'b0111,
    OpSub  = 4'b1000,
    OpSra  = 4'b1101
  } alu_op_t;

  localparam int unsigned FlagZero    = 0;
  localparam int unsigned FlagNeg     = 1;
  localparam int unsigned FlagOvf     = 2;
  localparam int unsigned FlagIllegal = 3;
  localparam int unsigned NumFlags    = 4;

  function automatic logic alu_op_legal(input logic [3:0] op);
    case (op)
      OpAdd, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpOr, OpAnd, OpSub, OpSra: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after i_ptr wins.
module rr_arbiter #(
  parameter int unsigned N   = 2,
  localparam int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IdW-1:0] i_ptr,
  output logic [N-1:0]   o_grant,
  output logic [IdW-1:0] o_idx,
  output logic           o_valid
);

  logic [IdW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IdW'((32'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin grants
// and a registered one-entry response slot tagged with the winner's index.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ*XLEN-1:0] i_req_a,
  input  logic [NUM_REQ*XLEN-1:0] i_req_b,
  input  logic [NUM_REQ*4-1:0]    i_req_op,
  output logic [XLEN-1:0]         o_alu_a,
  output logic [XLEN-1:0]         o_alu_b,
  output logic [3:0]              o_alu_op,
  input  logic [XLEN-1:0]         i_alu_result,
  input  logic                    i_alu_zero,
  input  logic                    i_alu_negative,
  input  logic                    i_alu_overflow,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [XLEN-1:0]         o_rsp_result,
  output logic [NumFlags-1:0]     o_rsp_flags,
  output logic                    o_busy
);

  if (XLEN != 32) begin : g_xlen_check
    $error("alu_arbiter: only XLEN=32 is supported");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
    $error("alu_arbiter: NUM_REQ must be in 2..8");
  end

  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [XLEN-1:0]     r_rsp_result;
  logic [NumFlags-1:0] r_rsp_flags;
  logic [ID_W-1:0]     r_rr_ptr;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_idx;
  logic                w_any;
  logic                w_can_issue;
  logic                w_fire;
  logic                w_illegal;
  logic [NumFlags-1:0] w_flags;
  logic [ID_W-1:0]     w_ptr_next;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .i_req  (i_req_valid),
    .i_ptr  (r_rr_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_valid(w_any)
  );

  // Reset also blocks grants so nothing is accepted while the slot is being cleared.
  assign w_can_issue = ~i_rst & (~r_rsp_valid | i_rsp_ready);
  assign w_fire      = w_any & w_can_issue;
  assign o_req_ready = w_can_issue ? w_grant : '0;
  assign w_ptr_next  = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);

  always_comb begin
    o_alu_a  = '0;
    o_alu_b  = '0;
    o_alu_op = 4'b0000;
    if (w_fire) begin
      o_alu_a  = i_req_a[XLEN*w_idx +: XLEN];
      o_alu_b  = i_req_b[XLEN*w_idx +: XLEN];
      o_alu_op = i_req_op[4*w_idx +: 4];
    end
  end

  // Illegal ops produce a zero result, so the zero flag is forced high with it.
  always_comb begin
    w_illegal            = ~alu_op_legal(o_alu_op);
    w_flags              = '0;
    w_flags[FlagIllegal] = w_illegal;
    w_flags[FlagOvf]     = w_illegal ? 1'b0 : i_alu_overflow;
    w_flags[FlagNeg]     = w_illegal ? 1'b0 : i_alu_negative;
    w_flags[FlagZero]    = w_illegal ? 1'b1 : i_alu_zero;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rr_ptr     <= '0;
    end else if (w_fire) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_idx;
      r_rsp_result <= w_illegal ? '0 : i_alu_result;
      r_rsp_flags  <= w_flags;
      r_rr_ptr     <= w_ptr_next;
    end else if (i_rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_flags  = r_rsp_flags;
  assign o_busy       = r_rsp_valid | (|i_req_valid);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU closing the loop.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_negative, alu_overflow;
  logic        rsp_valid, rsp_ready, busy;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NUM_REQ(2),
    .XLEN   (32)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .i_req_op      (req_op),
    .o_alu_a       (alu_a),
    .o_alu_b       (alu_b),
    .o_alu_op      (alu_op),
    .i_alu_result  (alu_result),
    .i_alu_zero    (alu_zero),
    .i_alu_negative(alu_negative),
    .i_alu_overflow(alu_overflow),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_id      (rsp_id),
    .o_rsp_result  (rsp_result),
    .o_rsp_flags   (rsp_flags),
    .o_busy        (busy)
  );

  // Behavioural ALU; undefined ops return junk so the arbiter must mask them.
  always_comb begin
    alu_overflow = 1'b0;
    case (alu_op)
      4'b0000: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'b1000: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'b0001: alu_result = alu_a << alu_b[4:0];
      4'b0010: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_result = {31'd0, alu_a < alu_b};
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0101: alu_result = alu_a >> alu_b[4:0];
      4'b0110: alu_result = alu_a | alu_b;
      4'b0111: alu_result = alu_a & alu_b;
      4'b1101: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: begin
        alu_result   = 32'hDEAD_BEEF;
        alu_overflow = 1'b1;
      end
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_negative = alu_result[31];
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    req_a = {32'd2, 32'd1}; req_b = {32'd2, 32'd1}; req_op = 8'h00;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready1 got=%b exp=00", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready2 got=%b exp=00", req_ready); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== 38'd0) begin
      failures++;
      $display("FAIL reset_rsp got v=%b id=%0d r=%h f=%b exp all zero", rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
    rst = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    req_a[31:0] = 32'd5; req_b[31:0] = 32'd7; req_op[3:0] = 4'b0000; req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      failures++;
      $display("FAIL single_issue got rdy=%b a=%0d b=%0d exp rdy=01 a=5 b=7", req_ready, alu_a, alu_b);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12 || rsp_flags !== 4'b0000) begin
      failures++;
      $display("FAIL single_rsp got v=%b id=%0d r=%0d f=%b exp v=1 id=0 r=12 f=0000", rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
    #1;
    checks++;
    if (alu_a !== 32'd0 || alu_op !== 4'b0000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_idle got a=%h op=%b busy=%b exp a=0 op=0000 busy=1", alu_a, alu_op, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_drain got v=%b busy=%b exp v=0 busy=0", rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_res;
    do_reset();
    rsp_ready = 1'b1;
    req_a = {32'h0000_00F0, 32'd10}; req_b = {32'h0000_000F, 32'd1}; req_op = {4'b0100, 4'b0000};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_res = (k % 2 == 0) ? 32'd11 : 32'h0000_00FF;
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++; $display("FAIL b2b_grant%0d got=%b exp=%b", k, req_ready, exp_rdy);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(k % 2) || rsp_result !== exp_res) begin
        failures++;
        $display("FAIL b2b_rsp%0d got v=%b id=%0d r=%h exp v=1 id=%0d r=%h", k, rsp_valid, rsp_id, rsp_result, k % 2, exp_res);
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_stall();
    do_reset();
    rsp_ready = 1'b0;
    req_a = {32'h8000_0000, 32'd3}; req_b = {32'd1, 32'd4}; req_op = {4'b1000, 4'b0000};
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL stall_first got=%b exp=10", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
        failures++;
        $display("FAIL stall_block%0d got rdy=%b a=%h b=%h exp rdy=00 a=0 b=0", k, req_ready, alu_a, alu_b);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'h7FFF_FFFF || rsp_flags !== 4'b0100) begin
        failures++;
        $display("FAIL stall_hold%0d got v=%b id=%0d r=%h f=%b exp v=1 id=1 r=7fffffff f=0100", k, rsp_valid, rsp_id, rsp_result, rsp_flags);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL stall_release got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd7) begin
      failures++;
      $display("FAIL stall_refill got v=%b id=%0d r=%0d exp v=1 id=0 r=7", rsp_valid, rsp_id, rsp_result);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    rsp_ready = 1'b1;
    req_a = {32'd9, 32'd3}; req_b = {32'd1, 32'd4}; req_op = {4'b0000, 4'b1111};
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL illegal_grant got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd0 || rsp_flags !== 4'b1001) begin
      failures++;
      $display("FAIL illegal_rsp got v=%b id=%0d r=%h f=%b exp v=1 id=0 r=0 f=1001", rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL illegal_ptr got=%b exp=10", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++;
    if (rsp_id !== 1'b1 || rsp_result !== 32'd10 || rsp_flags !== 4'b0000) begin
      failures++;
      $display("FAIL illegal_next got id=%0d r=%0d f=%b exp id=1 r=10 f=0000", rsp_id, rsp_result, rsp_flags);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b0;
    req_a = {32'd0, 32'd1}; req_b = {32'd0, 32'd1}; req_op = 8'h00;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd2) begin
      failures++; $display("FAIL midrst_pre got v=%b r=%0d exp v=1 r=2", rsp_valid, rsp_result);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0) begin
      failures++; $display("FAIL midrst_clear got v=%b r=%h exp v=0 r=0", rsp_valid, rsp_result);
    end
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL midrst_ptr got=%b exp=01", req_ready); end
    req_valid = 2'b00;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
